// File: rtl/io_ring_seq.sv
// Power-up / sleep sequencer for the GPIO pad ring: safe state, supply settle, staggered enables, reverse drain.
// Optional supply-loss handling (forced SAFE, sticky fault_o) is built with IO_SEQ_SUPPLY_LOSS_EN defined.
module io_ring_seq #(
    parameter int NPADS       = 32,
    parameter int GROUP       = 8,
    parameter int SETTLE_CYC  = 1024,
    parameter int STAGGER_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vddio_ok_i,
    input  logic             sleep_req_i,
    output logic             sleep_ack_o,
    output logic [NPADS-1:0] pad_ie_o,
    output logic [NPADS-1:0] pad_oe_en_o,
    output logic             ring_ready_o,
    output logic [2:0]       state_o,
    output logic             fault_o
);

    localparam int NG   = (NPADS + GROUP - 1) / GROUP;
    localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
    localparam int MAXC = (SETTLE_CYC > STAGGER_CYC) ? SETTLE_CYC : STAGGER_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        ST_SAFE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_IN_EN   = 3'd2,
        ST_OUT_STG = 3'd3,
        ST_READY   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_SLEEP   = 3'd6
    } state_t;

    logic             r_sync1;
    logic             r_ok_s;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [GW-1:0]    r_grp;
    logic [NPADS-1:0] r_ie;
    logic [NPADS-1:0] r_oe;
    logic             r_ready;
    logic             r_ack;
    logic             r_fault;

    state_t           w_state_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [GW-1:0]    w_grp_nx;
    logic [NPADS-1:0] w_ie_nx;
    logic [NPADS-1:0] w_oe_nx;
    logic             w_fault_nx;
    logic             w_cnt_zero;
    logic             w_grp_last;
    logic             w_grp_first;

    // Bits of the pad vector belonging to group g; the last group may be partial.
    function automatic logic [NPADS-1:0] group_mask(input logic [GW-1:0] g);
        logic [NPADS-1:0] m;
        for (int i = 0; i < NPADS; i++) begin
            m[i] = ((i / GROUP) == int'(g));
        end
        return m;
    endfunction

    assign w_cnt_zero  = (r_cnt == {CW{1'b0}});
    assign w_grp_last  = (r_grp == GW'(NG - 1));
    assign w_grp_first = (r_grp == {GW{1'b0}});

    // Two-flop synchronizer for the asynchronous supply-good flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_ok_s  <= 1'b0;
        end else begin
            r_sync1 <= vddio_ok_i;
            r_ok_s  <= r_sync1;
        end
    end

    // Next-state, counter, group pointer and pad-enable computation.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_grp_nx   = r_grp;
        w_ie_nx    = r_ie;
        w_oe_nx    = r_oe;
        w_fault_nx = r_fault;
        case (r_state)
            ST_SAFE: begin
                w_ie_nx = {NPADS{1'b0}};
                w_oe_nx = {NPADS{1'b0}};
                if (r_ok_s) begin
                    w_state_nx = ST_SETTLE;
                    w_cnt_nx   = CW'(SETTLE_CYC - 1);
                end else begin
                    w_state_nx = ST_SAFE;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_nx = ST_IN_EN;
                    w_ie_nx    = {NPADS{1'b1}};
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            ST_IN_EN: begin
                w_state_nx = ST_OUT_STG;
                w_grp_nx   = {GW{1'b0}};
                w_cnt_nx   = CW'(STAGGER_CYC - 1);
                w_oe_nx    = r_oe | group_mask({GW{1'b0}});
            end
            ST_OUT_STG: begin
                if (!w_cnt_zero) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else if (w_grp_last) begin
                    w_state_nx = ST_READY;
                end else begin
                    w_grp_nx = r_grp + GW'(1);
                    w_cnt_nx = CW'(STAGGER_CYC - 1);
                    w_oe_nx  = r_oe | group_mask(r_grp + GW'(1));
                end
            end
            ST_READY: begin
                if (sleep_req_i) begin
                    w_state_nx = ST_DRAIN;
                    w_grp_nx   = GW'(NG - 1);
                    w_cnt_nx   = CW'(STAGGER_CYC - 1);
                    w_oe_nx    = r_oe & ~group_mask(GW'(NG - 1));
                end else begin
                    w_state_nx = ST_READY;
                end
            end
            ST_DRAIN: begin
                // Drain runs to completion even if the request drops midway.
                if (!w_cnt_zero) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else if (w_grp_first) begin
                    w_state_nx = ST_SLEEP;
                    w_ie_nx    = {NPADS{1'b0}};
                end else begin
                    w_grp_nx = r_grp - GW'(1);
                    w_cnt_nx = CW'(STAGGER_CYC - 1);
                    w_oe_nx  = r_oe & ~group_mask(r_grp - GW'(1));
                end
            end
            ST_SLEEP: begin
                if (!sleep_req_i) begin
                    w_state_nx = ST_SETTLE;
                    w_cnt_nx   = CW'(SETTLE_CYC - 1);
                end else begin
                    w_state_nx = ST_SLEEP;
                end
            end
            default: begin
                w_state_nx = ST_SAFE;
                w_ie_nx    = {NPADS{1'b0}};
                w_oe_nx    = {NPADS{1'b0}};
            end
        endcase
`ifdef IO_SEQ_SUPPLY_LOSS_EN
        // Supply loss overrides everything, including a same-cycle sleep request.
        if ((r_state != ST_SAFE) && !r_ok_s) begin
            w_state_nx = ST_SAFE;
            w_ie_nx    = {NPADS{1'b0}};
            w_oe_nx    = {NPADS{1'b0}};
            if ((r_state == ST_READY) || (r_state == ST_DRAIN) || (r_state == ST_SLEEP)) begin
                w_fault_nx = 1'b1;
            end else begin
                w_fault_nx = r_fault;
            end
        end else begin
            w_fault_nx = r_fault;
        end
`else
        w_fault_nx = 1'b0;
`endif
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SAFE;
            r_cnt   <= {CW{1'b0}};
            r_grp   <= {GW{1'b0}};
            r_ie    <= {NPADS{1'b0}};
            r_oe    <= {NPADS{1'b0}};
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_grp   <= w_grp_nx;
            r_ie    <= w_ie_nx;
            r_oe    <= w_oe_nx;
            r_ready <= (w_state_nx == ST_READY);
            r_ack   <= (w_state_nx == ST_SLEEP);
            r_fault <= w_fault_nx;
        end
    end

    assign pad_ie_o     = r_ie;
    assign pad_oe_en_o  = r_oe;
    assign ring_ready_o = r_ready;
    assign sleep_ack_o  = r_ack;
    assign state_o      = r_state;
`ifdef IO_SEQ_SUPPLY_LOSS_EN
    assign fault_o      = r_fault;
`else
    assign fault_o      = 1'b0;
`endif

endmodule

// File: tb/tb_io_ring_seq.sv
// Bench for io_ring_seq: a 32-pad and a 20-pad instance checked every cycle against a timeline model.
module tb_io_ring_seq;
    localparam int S = 1024;
    localparam int T = 16;
    localparam int G = 8;
`ifdef IO_SEQ_SUPPLY_LOSS_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n_v = 2'b00;
    logic [1:0] ok_v    = 2'b00;
    logic [1:0] slp_v   = 2'b00;

    logic [31:0] ie0, oe0;
    logic [19:0] ie1, oe1;
    logic        ack0, ack1, rdy0, rdy1, flt0, flt1;
    logic [2:0]  st0, st1;

    logic [31:0] ob_ie, ob_oe;
    logic        ob_ack, ob_rdy, ob_flt;
    logic [2:0]  ob_st;

    int passed = 0;
    int total  = 0;

    io_ring_seq #(.NPADS(32), .GROUP(8), .SETTLE_CYC(S), .STAGGER_CYC(T)) u_dut32 (
        .clk(clk), .rst_n(rst_n_v[0]), .vddio_ok_i(ok_v[0]), .sleep_req_i(slp_v[0]),
        .sleep_ack_o(ack0), .pad_ie_o(ie0), .pad_oe_en_o(oe0), .ring_ready_o(rdy0),
        .state_o(st0), .fault_o(flt0));

    io_ring_seq #(.NPADS(20), .GROUP(8), .SETTLE_CYC(S), .STAGGER_CYC(T)) u_dut20 (
        .clk(clk), .rst_n(rst_n_v[1]), .vddio_ok_i(ok_v[1]), .sleep_req_i(slp_v[1]),
        .sleep_ack_o(ack1), .pad_ie_o(ie1), .pad_oe_en_o(oe1), .ring_ready_o(rdy1),
        .state_o(st1), .fault_o(flt1));

    function automatic int np_of(input int w);
        return (w != 0) ? 20 : 32;
    endfunction

    function automatic int ng_of(input int w);
        return (np_of(w) + G - 1) / G;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] low_bits(input int n);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = (i < n);
        return m;
    endfunction

    // Timeline model, r = edges since the settle counter was loaded.
    function automatic logic m_ie(input int r);
        return (r >= S);
    endfunction

    function automatic logic [31:0] m_oe_up(input int w, input int r);
        int ngr;
        ngr = (r < S + 1) ? 0 : imin(ng_of(w), (r - S - 1) / T + 1);
        return low_bits(imin(ngr * G, np_of(w)));
    endfunction

    function automatic logic m_rdy(input int w, input int r);
        return (r >= S + 1 + ng_of(w) * T);
    endfunction

    function automatic logic [2:0] m_st(input int w, input int r, input logic [2:0] pre);
        if (r < 0) return pre;
        if (r < S) return 3'd1;
        if (r == S) return 3'd2;
        if (r < S + 1 + ng_of(w) * T) return 3'd3;
        return 3'd4;
    endfunction

    task automatic get_obs(input int w);
        if (w != 0) begin
            ob_ie = {12'd0, ie1}; ob_oe = {12'd0, oe1};
            ob_ack = ack1; ob_rdy = rdy1; ob_flt = flt1; ob_st = st1;
        end else begin
            ob_ie = ie0; ob_oe = oe0;
            ob_ack = ack0; ob_rdy = rdy0; ob_flt = flt0; ob_st = st0;
        end
    endtask

    task automatic test_reset();
        #2;
        for (int w = 0; w < 2; w++) begin
            get_obs(w);
            total++;
            if ({ob_ie, ob_oe, ob_ack, ob_rdy, ob_flt, ob_st} !== 70'd0)
                $display("FAIL reset_state dut%0d got ie=%h oe=%h ack=%b rdy=%b flt=%b st=%0d want all 0",
                         w, ob_ie, ob_oe, ob_ack, ob_rdy, ob_flt, ob_st);
            else passed++;
        end
    endtask

    // Walks the power-up timeline from r_start to r_end; sleep_req noise must be ignored.
    task automatic up_phase(input int w, input int r_start, input int r_end, input logic [2:0] pre);
        for (int r = r_start; r <= r_end; r++) begin
            @(posedge clk); #1;
            get_obs(w);
            total++;
            if (ob_ie !== (m_ie(r) ? low_bits(np_of(w)) : 32'd0))
                $display("FAIL up_ie dut%0d r=%0d got %h want %h", w, r, ob_ie, m_ie(r) ? low_bits(np_of(w)) : 32'd0);
            else passed++;
            total++;
            if (ob_oe !== m_oe_up(w, r))
                $display("FAIL up_oe dut%0d r=%0d got %h want %h", w, r, ob_oe, m_oe_up(w, r));
            else passed++;
            total++;
            if (ob_rdy !== m_rdy(w, r))
                $display("FAIL up_ready dut%0d r=%0d got %b want %b", w, r, ob_rdy, m_rdy(w, r));
            else passed++;
            total++;
            if (ob_st !== m_st(w, r, pre))
                $display("FAIL up_state dut%0d r=%0d got %0d want %0d", w, r, ob_st, m_st(w, r, pre));
            else passed++;
            total++;
            if (ob_ack !== 1'b0)
                $display("FAIL up_ack dut%0d r=%0d got %b want 0", w, r, ob_ack);
            else passed++;
            slp_v[w] = (r < S + ng_of(w) * T - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic test_bringup(input int w, input int r_end);
        int idle;
        @(posedge clk); #1;
        rst_n_v[w] = 1'b0; ok_v[w] = 1'b0; slp_v[w] = 1'b0;
        @(posedge clk); #1;
        rst_n_v[w] = 1'b1;
        idle = int'($urandom_range(0, 4));
        for (int i = 0; i < idle; i++) begin
            @(posedge clk); #1;
            get_obs(w);
            total++;
            if (ob_st !== 3'd0 || ob_ie !== 32'd0)
                $display("FAIL idle_safe dut%0d got st=%0d ie=%h want st=0 ie=0", w, ob_st, ob_ie);
            else passed++;
            slp_v[w] = 1'($urandom_range(0, 1));
        end
        ok_v[w] = 1'b1;
        up_phase(w, -2, r_end, 3'd0);
    endtask

    task automatic test_drain(input int w);
        int ng, c, hold;
        ng = ng_of(w);
        hold = int'($urandom_range(1, 8));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            get_obs(w);
            total++;
            if (ob_rdy !== 1'b1 || ob_st !== 3'd4)
                $display("FAIL ready_hold dut%0d got rdy=%b st=%0d want 1/4", w, ob_rdy, ob_st);
            else passed++;
        end
        slp_v[w] = 1'b1;
        for (int d = 0; d <= ng * T + 2; d++) begin
            @(posedge clk); #1;
            get_obs(w);
            c = imin(ng, d / T + 1);
            total++;
            if (ob_oe !== low_bits(imin((ng - c) * G, np_of(w))))
                $display("FAIL drain_oe dut%0d d=%0d got %h want %h", w, d, ob_oe, low_bits(imin((ng - c) * G, np_of(w))));
            else passed++;
            total++;
            if (ob_ie !== ((d < ng * T) ? low_bits(np_of(w)) : 32'd0))
                $display("FAIL drain_ie dut%0d d=%0d got %h", w, d, ob_ie);
            else passed++;
            total++;
            if (ob_ack !== (d >= ng * T) || ob_rdy !== 1'b0)
                $display("FAIL drain_ack dut%0d d=%0d got ack=%b rdy=%b want ack=%b rdy=0", w, d, ob_ack, ob_rdy, d >= ng * T);
            else passed++;
            total++;
            if (ob_st !== ((d < ng * T) ? 3'd5 : 3'd6))
                $display("FAIL drain_state dut%0d d=%0d got %0d", w, d, ob_st);
            else passed++;
            slp_v[w] = (d < ng * T - 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        hold = int'($urandom_range(2, 6));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            get_obs(w);
            total++;
            if (ob_ack !== 1'b1 || ob_st !== 3'd6 || ob_oe !== 32'd0)
                $display("FAIL sleep_hold dut%0d got ack=%b st=%0d oe=%h want 1/6/0", w, ob_ack, ob_st, ob_oe);
            else passed++;
        end
    endtask

    task automatic test_wake(input int w);
        slp_v[w] = 1'b0;
        up_phase(w, 0, S + 1 + ng_of(w) * T + 2, 3'd6);
    endtask

    task automatic test_partial();
        test_bringup(1, S + 1 + ng_of(1) * T + 2);
        total++;
        if (oe1 !== 20'hFFFFF || ng_of(1) != 3)
            $display("FAIL partial_oe got %h want fffff", oe1);
        else passed++;
    endtask

    // ok falls after r_at; with the loss feature, SAFE and cleared outputs land on the third edge.
    task automatic test_loss(input int w, input int r_at, input logic exp_fault);
        slp_v[w] = 1'b0;
        ok_v[w]  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            get_obs(w);
            if (LOSS_EN && k >= 3) begin
                total++;
                if ({ob_ie, ob_oe, ob_rdy, ob_ack, ob_st} !== 69'd0)
                    $display("FAIL loss_safe dut%0d k=%0d got ie=%h oe=%h rdy=%b st=%0d want 0", w, k, ob_ie, ob_oe, ob_rdy, ob_st);
                else passed++;
                total++;
                if (ob_flt !== exp_fault)
                    $display("FAIL loss_fault dut%0d k=%0d got %b want %b", w, k, ob_flt, exp_fault);
                else passed++;
            end else begin
                total++;
                if (ob_oe !== m_oe_up(w, r_at + k) || ob_st !== m_st(w, r_at + k, 3'd0) || ob_rdy !== m_rdy(w, r_at + k))
                    $display("FAIL loss_hold dut%0d k=%0d got oe=%h st=%0d want oe=%h st=%0d", w, k, ob_oe, ob_st,
                             m_oe_up(w, r_at + k), m_st(w, r_at + k, 3'd0));
                else passed++;
                total++;
                if (ob_flt !== 1'b0)
                    $display("FAIL loss_fault_early dut%0d k=%0d got %b want 0", w, k, ob_flt);
                else passed++;
            end
        end
    endtask

    task automatic test_supply_loss();
        test_bringup(1, S + 1 + 2 * T + 5);
        test_loss(1, S + 1 + 2 * T + 5, 1'b0);
        test_loss(0, S + 1 + ng_of(0) * T + 2, 1'b1);
    endtask

    task automatic test_async_reset_drain();
        test_bringup(0, S + 1 + ng_of(0) * T + 2);
        slp_v[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (st0 !== 3'd5)
            $display("FAIL pre_reset_drain got st=%0d want 5", st0);
        else passed++;
        #2;
        rst_n_v[0] = 1'b0;
        #1;
        get_obs(0);
        total++;
        if ({ob_ie, ob_oe, ob_ack, ob_rdy, ob_flt, ob_st} !== 70'd0)
            $display("FAIL async_reset got ie=%h oe=%h ack=%b rdy=%b flt=%b st=%0d want all 0",
                     ob_ie, ob_oe, ob_ack, ob_rdy, ob_flt, ob_st);
        else passed++;
        slp_v[0] = 1'b0;
        test_bringup(0, S + 1 + ng_of(0) * T + 2);
    endtask

    initial begin
        test_reset();
        test_bringup(0, S + 1 + ng_of(0) * T + 2);
        test_drain(0);
        test_wake(0);
        test_partial();
        test_supply_loss();
        test_async_reset_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
